// File: rtl/rvfi_modport.sv
// Registered RVFI retirement-trace producer: captures one normalized retirement
// record per cycle and stamps it with a monotonically increasing order number.
module rvfi_modport #(
    parameter int ILEN           = 32,
    parameter int XLEN           = 32,
    parameter int ORDER_WL       = 64,
    parameter int MAX_INTR_ID_WL = 11,
    parameter int MODE_WL        = 2,
    parameter int IXL_WL         = 2,
    parameter int GPR_ADDR_WL    = 5
) (
    input  logic                      clk,
    input  logic                      reset_n,

    input  logic                      ret_valid,
    input  logic [ILEN-1:0]           ret_insn,
    input  logic                      ret_trap,
    input  logic                      ret_halt,
    input  logic                      ret_intr,
    input  logic [MAX_INTR_ID_WL-1:0] ret_intr_id,
    input  logic [MODE_WL-1:0]        ret_mode,
    input  logic [XLEN-1:0]           ret_pc_rdata,
    input  logic [XLEN-1:0]           ret_pc_wdata,
    input  logic [GPR_ADDR_WL-1:0]    ret_rs1_addr,
    input  logic [GPR_ADDR_WL-1:0]    ret_rs2_addr,
    input  logic [GPR_ADDR_WL-1:0]    ret_rs3_addr,
    input  logic [XLEN-1:0]           ret_rs1_rdata,
    input  logic [XLEN-1:0]           ret_rs2_rdata,
    input  logic [XLEN-1:0]           ret_rs3_rdata,
    input  logic [GPR_ADDR_WL-1:0]    ret_rd1_addr,
    input  logic [GPR_ADDR_WL-1:0]    ret_rd2_addr,
    input  logic [XLEN-1:0]           ret_rd1_wdata,
    input  logic [XLEN-1:0]           ret_rd2_wdata,
    input  logic [XLEN-1:0]           ret_mem_addr,
    input  logic [XLEN-1:0]           ret_mem_rdata,
    input  logic [XLEN-1:0]           ret_mem_wdata,
    input  logic [XLEN/8-1:0]         ret_mem_rmask,
    input  logic [XLEN/8-1:0]         ret_mem_wmask,
    input  logic [ILEN-1:0]           csr_mcause_i,
    input  logic [ILEN-1:0]           csr_mip_i,

    output logic                      rvfi_valid,
    output logic [ORDER_WL-1:0]       rvfi_order,
    output logic [ILEN-1:0]           rvfi_insn,
    output logic                      rvfi_trap,
    output logic                      rvfi_halt,
    output logic                      rvfi_intr,
    output logic [MAX_INTR_ID_WL-1:0] rvfi_intr_id,
    output logic [MODE_WL-1:0]        rvfi_mode,
    output logic [IXL_WL-1:0]         rvfi_ixl,
    output logic [XLEN-1:0]           rvfi_pc_rdata,
    output logic [XLEN-1:0]           rvfi_pc_wdata,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rs1_addr,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rs2_addr,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rs3_addr,
    output logic [XLEN-1:0]           rvfi_rs1_rdata,
    output logic [XLEN-1:0]           rvfi_rs2_rdata,
    output logic [XLEN-1:0]           rvfi_rs3_rdata,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rd1_addr,
    output logic [GPR_ADDR_WL-1:0]    rvfi_rd2_addr,
    output logic [XLEN-1:0]           rvfi_rd1_wdata,
    output logic [XLEN-1:0]           rvfi_rd2_wdata,
    output logic [XLEN-1:0]           rvfi_mem_addr,
    output logic [XLEN-1:0]           rvfi_mem_rdata,
    output logic [XLEN-1:0]           rvfi_mem_wdata,
    output logic [XLEN/8-1:0]         rvfi_mem_rmask,
    output logic [XLEN/8-1:0]         rvfi_mem_wmask,
    output logic [ILEN-1:0]           csr_mcause,
    output logic [ILEN-1:0]           csr_mip
);

    localparam logic [IXL_WL-1:0] IXL_VALUE = (XLEN == 64) ? IXL_WL'(2) : IXL_WL'(1);

    logic [ORDER_WL-1:0] order_cnt;
    logic                rmask_none;
    logic                wmask_none;

    assign rmask_none = (ret_mem_rmask == '0);
    assign wmask_none = (ret_mem_wmask == '0);

    // IXL is a pure function of XLEN, so it needs no flop and is valid even in reset.
    assign rvfi_ixl = IXL_VALUE;

    // NOTE: every register here uses <= so all fields update together from the
    // pre-edge values; blocking writes would let later lines see half-updated state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            order_cnt      <= '0;
            rvfi_valid     <= 1'b0;
            rvfi_order     <= '0;
            rvfi_insn      <= '0;
            rvfi_trap      <= 1'b0;
            rvfi_halt      <= 1'b0;
            rvfi_intr      <= 1'b0;
            rvfi_intr_id   <= '0;
            rvfi_mode      <= '0;
            rvfi_pc_rdata  <= '0;
            rvfi_pc_wdata  <= '0;
            rvfi_rs1_addr  <= '0;
            rvfi_rs2_addr  <= '0;
            rvfi_rs3_addr  <= '0;
            rvfi_rs1_rdata <= '0;
            rvfi_rs2_rdata <= '0;
            rvfi_rs3_rdata <= '0;
            rvfi_rd1_addr  <= '0;
            rvfi_rd2_addr  <= '0;
            rvfi_rd1_wdata <= '0;
            rvfi_rd2_wdata <= '0;
            rvfi_mem_addr  <= '0;
            rvfi_mem_rdata <= '0;
            rvfi_mem_wdata <= '0;
            rvfi_mem_rmask <= '0;
            rvfi_mem_wmask <= '0;
            csr_mcause     <= '0;
            csr_mip        <= '0;
        end else begin
            rvfi_valid <= ret_valid;
            // Record fields only load on a retirement; idle cycles hold the last record.
            if (ret_valid) begin
                order_cnt      <= order_cnt + ORDER_WL'(1);
                rvfi_order     <= order_cnt;
                rvfi_insn      <= ret_insn;
                rvfi_trap      <= ret_trap;
                rvfi_halt      <= ret_halt;
                rvfi_intr      <= ret_intr;
                rvfi_intr_id   <= ret_intr ? ret_intr_id : '0;
                rvfi_mode      <= ret_mode;
                rvfi_pc_rdata  <= ret_pc_rdata;
                rvfi_pc_wdata  <= ret_pc_wdata;
                rvfi_rs1_addr  <= ret_rs1_addr;
                rvfi_rs2_addr  <= ret_rs2_addr;
                rvfi_rs3_addr  <= ret_rs3_addr;
                rvfi_rs1_rdata <= (ret_rs1_addr == '0) ? '0 : ret_rs1_rdata;
                rvfi_rs2_rdata <= (ret_rs2_addr == '0) ? '0 : ret_rs2_rdata;
                rvfi_rs3_rdata <= (ret_rs3_addr == '0) ? '0 : ret_rs3_rdata;
                rvfi_rd1_addr  <= ret_rd1_addr;
                rvfi_rd2_addr  <= ret_rd2_addr;
                rvfi_rd1_wdata <= (ret_rd1_addr == '0) ? '0 : ret_rd1_wdata;
                rvfi_rd2_wdata <= (ret_rd2_addr == '0) ? '0 : ret_rd2_wdata;
                rvfi_mem_addr  <= (rmask_none && wmask_none) ? '0 : ret_mem_addr;
                rvfi_mem_rdata <= rmask_none ? '0 : ret_mem_rdata;
                rvfi_mem_wdata <= wmask_none ? '0 : ret_mem_wdata;
                rvfi_mem_rmask <= ret_mem_rmask;
                rvfi_mem_wmask <= ret_mem_wmask;
                csr_mcause     <= csr_mcause_i;
                csr_mip        <= csr_mip_i;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_modport.sv
// Directed self-checking bench for rvfi_modport: inputs change on the falling
// edge, outputs are sampled on the following falling edge.
module tb_rvfi_modport;

    logic        clk;
    logic        reset_n;
    logic        ret_valid;
    logic [31:0] ret_insn;
    logic        ret_trap, ret_halt, ret_intr;
    logic [10:0] ret_intr_id;
    logic [1:0]  ret_mode;
    logic [31:0] ret_pc_rdata, ret_pc_wdata;
    logic [4:0]  ret_rs1_addr, ret_rs2_addr, ret_rs3_addr;
    logic [31:0] ret_rs1_rdata, ret_rs2_rdata, ret_rs3_rdata;
    logic [4:0]  ret_rd1_addr, ret_rd2_addr;
    logic [31:0] ret_rd1_wdata, ret_rd2_wdata;
    logic [31:0] ret_mem_addr, ret_mem_rdata, ret_mem_wdata;
    logic [3:0]  ret_mem_rmask, ret_mem_wmask;
    logic [31:0] csr_mcause_i, csr_mip_i;

    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [10:0] rvfi_intr_id;
    logic [1:0]  rvfi_mode, rvfi_ixl;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs3_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rs3_rdata;
    logic [4:0]  rvfi_rd1_addr, rvfi_rd2_addr;
    logic [31:0] rvfi_rd1_wdata, rvfi_rd2_wdata;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic [31:0] csr_mcause, csr_mip;

    int checks;
    int failures;

    rvfi_modport dut (
        .clk(clk), .reset_n(reset_n),
        .ret_valid(ret_valid), .ret_insn(ret_insn), .ret_trap(ret_trap),
        .ret_halt(ret_halt), .ret_intr(ret_intr), .ret_intr_id(ret_intr_id),
        .ret_mode(ret_mode), .ret_pc_rdata(ret_pc_rdata), .ret_pc_wdata(ret_pc_wdata),
        .ret_rs1_addr(ret_rs1_addr), .ret_rs2_addr(ret_rs2_addr), .ret_rs3_addr(ret_rs3_addr),
        .ret_rs1_rdata(ret_rs1_rdata), .ret_rs2_rdata(ret_rs2_rdata), .ret_rs3_rdata(ret_rs3_rdata),
        .ret_rd1_addr(ret_rd1_addr), .ret_rd2_addr(ret_rd2_addr),
        .ret_rd1_wdata(ret_rd1_wdata), .ret_rd2_wdata(ret_rd2_wdata),
        .ret_mem_addr(ret_mem_addr), .ret_mem_rdata(ret_mem_rdata), .ret_mem_wdata(ret_mem_wdata),
        .ret_mem_rmask(ret_mem_rmask), .ret_mem_wmask(ret_mem_wmask),
        .csr_mcause_i(csr_mcause_i), .csr_mip_i(csr_mip_i),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_intr_id(rvfi_intr_id), .rvfi_mode(rvfi_mode), .rvfi_ixl(rvfi_ixl),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr), .rvfi_rs3_addr(rvfi_rs3_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata), .rvfi_rs3_rdata(rvfi_rs3_rdata),
        .rvfi_rd1_addr(rvfi_rd1_addr), .rvfi_rd2_addr(rvfi_rd2_addr),
        .rvfi_rd1_wdata(rvfi_rd1_wdata), .rvfi_rd2_wdata(rvfi_rd2_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rdata(rvfi_mem_rdata), .rvfi_mem_wdata(rvfi_mem_wdata),
        .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .csr_mcause(csr_mcause), .csr_mip(csr_mip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_inputs();
        ret_valid = 1'b0; ret_insn = '0; ret_trap = 1'b0; ret_halt = 1'b0;
        ret_intr = 1'b0; ret_intr_id = '0; ret_mode = 2'd3;
        ret_pc_rdata = '0; ret_pc_wdata = '0;
        ret_rs1_addr = '0; ret_rs2_addr = '0; ret_rs3_addr = '0;
        ret_rs1_rdata = '0; ret_rs2_rdata = '0; ret_rs3_rdata = '0;
        ret_rd1_addr = '0; ret_rd2_addr = '0; ret_rd1_wdata = '0; ret_rd2_wdata = '0;
        ret_mem_addr = '0; ret_mem_rdata = '0; ret_mem_wdata = '0;
        ret_mem_rmask = '0; ret_mem_wmask = '0;
        csr_mcause_i = '0; csr_mip_i = '0;
    endtask

    // Sets up a plain retirement at pc; the caller adds any extra fields.
    task automatic set_rec(input logic [31:0] pc, input logic [31:0] insn);
        clear_inputs();
        ret_valid    = 1'b1;
        ret_pc_rdata = pc;
        ret_pc_wdata = pc + 32'd4;
        ret_insn     = insn;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_rec(32'h40, 32'h13);
        repeat (2) @(negedge clk);
        checks++; if (rvfi_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rvfi_valid); end
        checks++; if (rvfi_order !== 64'd0) begin failures++; $display("FAIL reset_order got=%0d exp=0", rvfi_order); end
        checks++; if (rvfi_pc_rdata !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", rvfi_pc_rdata); end
        checks++; if (rvfi_insn !== 32'd0) begin failures++; $display("FAIL reset_insn got=%h exp=0", rvfi_insn); end
        checks++; if (rvfi_mode !== 2'd0) begin failures++; $display("FAIL reset_mode got=%0d exp=0", rvfi_mode); end
        checks++; if (rvfi_ixl !== 2'd1) begin failures++; $display("FAIL reset_ixl got=%0d exp=1", rvfi_ixl); end
        clear_inputs();
        reset_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] pcs [3];
        pcs[0] = 32'h80; pcs[1] = 32'h84; pcs[2] = 32'h88;
        apply_reset();
        @(negedge clk);
        checks++; if (rvfi_valid !== 1'b0) begin failures++; $display("FAIL b2b_pre_valid got=%0b exp=0", rvfi_valid); end
        set_rec(pcs[0], 32'h0000_0013);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (rvfi_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", i, rvfi_valid); end
            checks++; if (rvfi_order !== 64'(i)) begin failures++; $display("FAIL b2b_order[%0d] got=%0d exp=%0d", i, rvfi_order, i); end
            checks++; if (rvfi_pc_rdata !== pcs[i]) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, rvfi_pc_rdata, pcs[i]); end
            checks++; if (rvfi_pc_wdata !== pcs[i] + 32'd4) begin failures++; $display("FAIL b2b_npc[%0d] got=%h exp=%h", i, rvfi_pc_wdata, pcs[i] + 32'd4); end
            checks++; if (rvfi_mode !== 2'd3) begin failures++; $display("FAIL b2b_mode[%0d] got=%0d exp=3", i, rvfi_mode); end
            if (i < 2) set_rec(pcs[i+1], 32'h0000_0013 + 32'(i + 1));
            else clear_inputs();
        end
        @(negedge clk);
        checks++; if (rvfi_valid !== 1'b0) begin failures++; $display("FAIL b2b_post_valid got=%0b exp=0", rvfi_valid); end
        checks++; if (rvfi_insn !== 32'h15) begin failures++; $display("FAIL b2b_hold_insn got=%h exp=15", rvfi_insn); end
    endtask

    task automatic test_gap();
        logic exp_valid [4];
        exp_valid[0] = 1'b1; exp_valid[1] = 1'b0; exp_valid[2] = 1'b0; exp_valid[3] = 1'b1;
        apply_reset();
        @(negedge clk);
        set_rec(32'h100, 32'h0030_0093);
        ret_rd1_addr = 5'd3; ret_rd1_wdata = 32'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (rvfi_valid !== exp_valid[i]) begin failures++; $display("FAIL gap_valid[%0d] got=%0b exp=%0b", i, rvfi_valid, exp_valid[i]); end
            if (i < 3) begin
                checks++; if (rvfi_order !== 64'd0) begin failures++; $display("FAIL gap_hold_order[%0d] got=%0d exp=0", i, rvfi_order); end
                checks++; if (rvfi_pc_rdata !== 32'h100) begin failures++; $display("FAIL gap_hold_pc[%0d] got=%h exp=100", i, rvfi_pc_rdata); end
                checks++; if (rvfi_rd1_wdata !== 32'h55) begin failures++; $display("FAIL gap_hold_rd1[%0d] got=%h exp=55", i, rvfi_rd1_wdata); end
            end
            if (i == 2) set_rec(32'h200, 32'h13);
            else clear_inputs();
        end
        checks++; if (rvfi_order !== 64'd1) begin failures++; $display("FAIL gap_order2 got=%0d exp=1", rvfi_order); end
        checks++; if (rvfi_pc_rdata !== 32'h200) begin failures++; $display("FAIL gap_pc2 got=%h exp=200", rvfi_pc_rdata); end
        checks++; if (rvfi_rd1_wdata !== 32'h0) begin failures++; $display("FAIL gap_rd1_2 got=%h exp=0", rvfi_rd1_wdata); end
    endtask

    task automatic test_zero_regs();
        @(negedge clk);
        set_rec(32'h300, 32'h13);
        ret_rd1_addr = 5'd0; ret_rd1_wdata = 32'hDEADBEEF;
        ret_rs1_addr = 5'd0; ret_rs1_rdata = 32'd5;
        ret_rs2_addr = 5'd2; ret_rs2_rdata = 32'h22;
        ret_rs3_addr = 5'd0; ret_rs3_rdata = 32'h33;
        ret_rd2_addr = 5'd7; ret_rd2_wdata = 32'h77;
        @(negedge clk);
        clear_inputs();
        checks++; if (rvfi_rd1_wdata !== 32'h0) begin failures++; $display("FAIL zero_rd1 got=%h exp=0", rvfi_rd1_wdata); end
        checks++; if (rvfi_rs1_rdata !== 32'h0) begin failures++; $display("FAIL zero_rs1 got=%h exp=0", rvfi_rs1_rdata); end
        checks++; if (rvfi_rs2_rdata !== 32'h22) begin failures++; $display("FAIL zero_rs2 got=%h exp=22", rvfi_rs2_rdata); end
        checks++; if (rvfi_rs3_rdata !== 32'h0) begin failures++; $display("FAIL zero_rs3 got=%h exp=0", rvfi_rs3_rdata); end
        checks++; if (rvfi_rd2_wdata !== 32'h77) begin failures++; $display("FAIL zero_rd2 got=%h exp=77", rvfi_rd2_wdata); end
        checks++; if (rvfi_rs2_addr !== 5'd2) begin failures++; $display("FAIL zero_rs2_addr got=%0d exp=2", rvfi_rs2_addr); end
    endtask

    task automatic test_mem();
        @(negedge clk);
        set_rec(32'h400, 32'h00f12023);
        ret_mem_addr = 32'h1000; ret_mem_wmask = 4'hF; ret_mem_wdata = 32'h12345678;
        ret_mem_rmask = 4'h0; ret_mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        checks++; if (rvfi_mem_wdata !== 32'h12345678) begin failures++; $display("FAIL mem_store_wdata got=%h exp=12345678", rvfi_mem_wdata); end
        checks++; if (rvfi_mem_rdata !== 32'h0) begin failures++; $display("FAIL mem_store_rdata got=%h exp=0", rvfi_mem_rdata); end
        checks++; if (rvfi_mem_addr !== 32'h1000) begin failures++; $display("FAIL mem_store_addr got=%h exp=1000", rvfi_mem_addr); end
        checks++; if (rvfi_mem_wmask !== 4'hF) begin failures++; $display("FAIL mem_store_wmask got=%h exp=f", rvfi_mem_wmask); end
        set_rec(32'h404, 32'h00012083);
        ret_mem_addr = 32'h2000; ret_mem_rmask = 4'h3; ret_mem_rdata = 32'hAABB;
        ret_mem_wmask = 4'h0; ret_mem_wdata = 32'h99;
        @(negedge clk);
        checks++; if (rvfi_mem_rdata !== 32'hAABB) begin failures++; $display("FAIL mem_load_rdata got=%h exp=aabb", rvfi_mem_rdata); end
        checks++; if (rvfi_mem_wdata !== 32'h0) begin failures++; $display("FAIL mem_load_wdata got=%h exp=0", rvfi_mem_wdata); end
        checks++; if (rvfi_mem_rmask !== 4'h3) begin failures++; $display("FAIL mem_load_rmask got=%h exp=3", rvfi_mem_rmask); end
        set_rec(32'h408, 32'h13);
        ret_mem_addr = 32'h3000; ret_mem_rdata = 32'h1; ret_mem_wdata = 32'h2;
        @(negedge clk);
        clear_inputs();
        checks++; if (rvfi_mem_addr !== 32'h0) begin failures++; $display("FAIL mem_none_addr got=%h exp=0", rvfi_mem_addr); end
        checks++; if (rvfi_mem_rdata !== 32'h0) begin failures++; $display("FAIL mem_none_rdata got=%h exp=0", rvfi_mem_rdata); end
        checks++; if (rvfi_mem_wdata !== 32'h0) begin failures++; $display("FAIL mem_none_wdata got=%h exp=0", rvfi_mem_wdata); end
    endtask

    task automatic test_intr();
        @(negedge clk);
        set_rec(32'h500, 32'h13);
        ret_intr = 1'b1; ret_intr_id = 11'd7;
        csr_mcause_i = 32'h80000007; csr_mip_i = 32'h80;
        @(negedge clk);
        checks++; if (rvfi_intr !== 1'b1) begin failures++; $display("FAIL intr_flag got=%0b exp=1", rvfi_intr); end
        checks++; if (rvfi_intr_id !== 11'd7) begin failures++; $display("FAIL intr_id got=%0d exp=7", rvfi_intr_id); end
        checks++; if (csr_mcause !== 32'h80000007) begin failures++; $display("FAIL intr_mcause got=%h exp=80000007", csr_mcause); end
        checks++; if (csr_mip !== 32'h80) begin failures++; $display("FAIL intr_mip got=%h exp=80", csr_mip); end
        checks++; if (rvfi_trap !== 1'b0) begin failures++; $display("FAIL intr_trap got=%0b exp=0", rvfi_trap); end
        set_rec(32'h504, 32'h13);
        ret_intr = 1'b0; ret_intr_id = 11'd5; ret_trap = 1'b1; ret_halt = 1'b1;
        csr_mcause_i = 32'h2; csr_mip_i = 32'h0;
        @(negedge clk);
        clear_inputs();
        csr_mcause_i = 32'h123; csr_mip_i = 32'h888;
        checks++; if (rvfi_intr_id !== 11'd0) begin failures++; $display("FAIL nointr_id got=%0d exp=0", rvfi_intr_id); end
        checks++; if (rvfi_trap !== 1'b1) begin failures++; $display("FAIL trap_flag got=%0b exp=1", rvfi_trap); end
        checks++; if (rvfi_halt !== 1'b1) begin failures++; $display("FAIL halt_flag got=%0b exp=1", rvfi_halt); end
        @(negedge clk);
        checks++; if (csr_mcause !== 32'h2) begin failures++; $display("FAIL csr_hold_mcause got=%h exp=2", csr_mcause); end
        checks++; if (csr_mip !== 32'h0) begin failures++; $display("FAIL csr_hold_mip got=%h exp=0", csr_mip); end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            set_rec(32'h600 + 32'(4 * i), 32'h13);
            @(negedge clk);
        end
        // ret_valid is still high here: a seventh record is in flight.
        set_rec(32'h618, 32'h13);
        checks++; if (rvfi_order !== 64'd5) begin failures++; $display("FAIL mid_order5 got=%0d exp=5", rvfi_order); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if (rvfi_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%0b exp=0", rvfi_valid); end
        checks++; if (rvfi_order !== 64'd0) begin failures++; $display("FAIL mid_async_order got=%0d exp=0", rvfi_order); end
        checks++; if (rvfi_pc_rdata !== 32'd0) begin failures++; $display("FAIL mid_async_pc got=%h exp=0", rvfi_pc_rdata); end
        checks++; if (rvfi_insn !== 32'd0) begin failures++; $display("FAIL mid_async_insn got=%h exp=0", rvfi_insn); end
        checks++; if (rvfi_ixl !== 2'd1) begin failures++; $display("FAIL mid_async_ixl got=%0d exp=1", rvfi_ixl); end
        @(negedge clk);
        checks++; if (rvfi_valid !== 1'b0) begin failures++; $display("FAIL mid_held_valid got=%0b exp=0", rvfi_valid); end
        reset_n = 1'b1;
        set_rec(32'h700, 32'h13);
        @(negedge clk);
        clear_inputs();
        checks++; if (rvfi_valid !== 1'b1) begin failures++; $display("FAIL mid_after_valid got=%0b exp=1", rvfi_valid); end
        checks++; if (rvfi_order !== 64'd0) begin failures++; $display("FAIL mid_after_order got=%0d exp=0", rvfi_order); end
        checks++; if (rvfi_pc_rdata !== 32'h700) begin failures++; $display("FAIL mid_after_pc got=%h exp=700", rvfi_pc_rdata); end
        checks++; if (rvfi_ixl !== 2'd1) begin failures++; $display("FAIL mid_after_ixl got=%0d exp=1", rvfi_ixl); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_gap();
        test_zero_regs();
        test_mem();
        test_intr();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
